fifo_wr_arbiter: RTL and testbench

- Write-side scheduler for the team's async FIFO (FIFO_TOP). It shares the single FIFO write port among NUM_REQ requesters.
- Arbitration is round-robin with bounded bursts.
- Lives entirely in the FIFO write-clock domain. It drives w_data/w_inc and honours wfull so no word is written into a full FIFO or lost.
- Grant state is registered. Write strobe and ready are combinational from the registered grant and wfull, so a wfull assertion blocks the write in the same cycle.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write/read-side schedulers.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package fifo_arb_pkg;

  // Scheduler FSM encoding
  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  // Ceiling log2, floored at 1 so a derived width is never zero
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first valid index after last_id, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; it only ranks the current request vector.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] last_id,
  output logic                pick_valid,
  output logic [ID_WIDTH-1:0] pick_id
);

  // Rank each index by its distance after last_id; the lowest-ranked valid one wins
  always_comb begin
    int best;
    int rank;
    best       = NUM_REQ;
    rank       = 0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (j > int'(last_id)) begin
        rank = j - int'(last_id) - 1;
      end else begin
        rank = j + NUM_REQ - int'(last_id) - 1;
      end
      if (req_valid[j] && (rank < best)) begin
        best       = rank;
        pick_valid = 1'b1;
        pick_id    = ID_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded scheduler sharing one async-FIFO write port among NUM_REQ requesters.
// Latency: 1 cycle from request to grant; write strobe combinational from registered grant.
// Backpressure: wfull stalls the granted requester in the same cycle without releasing the grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  localparam int ID_WIDTH  = clog2(NUM_REQ)
) (
  input  logic                          w_clk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic                          w_inc,
  output logic                          gnt_valid,
  output logic [ID_WIDTH-1:0]           gnt_id,
  output logic                          burst_done
);

  localparam int CNT_WIDTH = clog2(BURST_LEN + 1);

  logic                  state_q, state_d;
  logic [ID_WIDTH-1:0]   gnt_id_q, gnt_id_d;
  logic [ID_WIDTH-1:0]   last_id_q, last_id_d;
  logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

  logic                  pick_valid;
  logic [ID_WIDTH-1:0]   pick_id;
  logic                  in_grant;
  logic                  sel_vld;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  xfer;
  logic                  release_gnt;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req_valid  (req_valid),
    .last_id    (last_id_q),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  // Select the granted lane and drive the write port; reset gates every strobe
  always_comb begin
    in_grant = (state_q == GRANT);
    sel_vld  = 1'b0;
    sel_dat  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_id_q == ID_WIDTH'(j)) begin
        sel_vld = req_valid[j];
        sel_dat = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    xfer = in_grant & sel_vld & ~wfull & wrst_n;
    // A dropped valid releases even while full; otherwise only the last beat does
    release_gnt = in_grant & (~sel_vld | (xfer & (burst_cnt_q == CNT_WIDTH'(BURST_LEN - 1))));
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = in_grant & ~wfull & wrst_n & (gnt_id_q == ID_WIDTH'(j));
    end
    w_inc      = xfer;
    w_data     = xfer ? sel_dat : '0;
    gnt_valid  = in_grant;
    gnt_id     = gnt_id_q;
    burst_done = release_gnt & wrst_n;
  end

  // Next grant state: arbitrate in IDLE, count beats and release in GRANT
  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE) begin
      if (pick_valid) begin
        gnt_id_d    = pick_id;
        burst_cnt_d = '0;
        state_d     = GRANT;
      end
    end else begin
      if (release_gnt) begin
        state_d   = IDLE;
        last_id_d = gnt_id_q;
      end else if (xfer) begin
        burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Grant registers; last_id resets to the top index so index 0 wins first
  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      last_id_q   <= ID_WIDTH'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: scoreboard of expected writes plus cycle-exact checks.
// Latency: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: wfull driven directly by the bench.
module tb_fifo_wr_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] dat;
    logic       last;
  } exp_t;

  logic        w_clk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic [7:0]  w_data;
  logic        w_inc;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic        burst_done;

  logic [7:0]  src_cnt [4];
  exp_t        sb [$];
  int          n_vec;
  int          n_miss;
  int          wr_cnt;
  int          cyc;

  fifo_wr_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .BURST_LEN  (4)
  ) dut (
    .w_clk      (w_clk),
    .wrst_n     (wrst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wfull      (wfull),
    .w_data     (w_data),
    .w_inc      (w_inc),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id),
    .burst_done (burst_done)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Requester i presents word i*16 + (words already accepted from it)
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = 8'(i * 16) + src_cnt[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_burst(input int id, input int start, input int n, input bit last_on_end);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = 2'(id);
      e.dat  = 8'(id * 16 + start + k);
      e.last = last_on_end && (k == n - 1);
      sb.push_back(e);
    end
  endtask

  // Falling-edge monitor: scoreboard every write, track requester handshakes
  task automatic mon();
    exp_t e;
    if (w_inc) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(w_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("w_data", 32'(w_data), 32'(e.dat));
        chk("wr_gnt_id", 32'(gnt_id), 32'(e.id));
        chk("wr_burst_done", 32'(burst_done), 32'(e.last));
        chk("wr_req_ready", 32'(req_ready), 32'(1) << e.id);
      end
      wr_cnt = wr_cnt + 1;
    end else begin
      chk("w_data_idle", 32'(w_data), 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        src_cnt[i] = src_cnt[i] + 8'd1;
      end
    end
  endtask

  task automatic wait_neg();
    @(negedge w_clk);
    mon();
  endtask

  task automatic wait_pos();
    @(posedge w_clk);
    #1;
  endtask

  // Run cycles until n more writes have been observed; returns cycles used
  task automatic run_writes(input int n, input int budget, output int cycles);
    int target;
    target = wr_cnt + n;
    cycles = 0;
    while ((wr_cnt < target) && (cycles < budget)) begin
      wait_neg();
      cycles = cycles + 1;
      wait_pos();
    end
    if (wr_cnt < target) begin
      chk("write_timeout", 32'(wr_cnt), 32'(target));
    end
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    wr_cnt    = 0;
    wrst_n    = 1'b0;
    wfull     = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) src_cnt[i] = 8'd0;

    // Reset held 3 cycles with every requester valid
    for (int k = 0; k < 3; k++) begin
      wait_neg();
      chk("rst_w_inc", 32'(w_inc), 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
      chk("rst_burst_done", 32'(burst_done), 32'h0);
      wait_pos();
    end
    wrst_n = 1'b1;

    // All four valid: grants 0,1,2,3,0,1, 4 words each, one idle cycle between
    push_burst(0, 0, 4, 1'b1);
    push_burst(1, 0, 4, 1'b1);
    push_burst(2, 0, 4, 1'b1);
    push_burst(3, 0, 4, 1'b1);
    push_burst(0, 4, 4, 1'b1);
    push_burst(1, 4, 4, 1'b1);
    run_writes(24, 60, cyc);
    chk("rr_cycles", 32'(cyc), 32'd30);
    req_valid = 4'h0;

    // Single requester 2: two back-to-back bursts 0x20..0x27
    for (int i = 0; i < 4; i++) src_cnt[i] = 8'd0;
    req_valid = 4'b0100;
    push_burst(2, 0, 4, 1'b1);
    push_burst(2, 4, 4, 1'b1);
    run_writes(8, 40, cyc);
    chk("single_cycles", 32'(cyc), 32'd10);
    req_valid = 4'h0;

    // wfull stall for 3 cycles after the 2nd word of requester 1
    for (int i = 0; i < 4; i++) src_cnt[i] = 8'd0;
    req_valid = 4'b0010;
    push_burst(1, 0, 4, 1'b1);
    run_writes(2, 10, cyc);
    chk("stall_pre_cycles", 32'(cyc), 32'd3);
    wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_neg();
      chk("stall_w_inc", 32'(w_inc), 32'h0);
      chk("stall_req_ready", 32'(req_ready), 32'h0);
      chk("stall_gnt_valid", 32'(gnt_valid), 32'h1);
      chk("stall_gnt_id", 32'(gnt_id), 32'h1);
      chk("stall_burst_done", 32'(burst_done), 32'h0);
      wait_pos();
    end
    wfull = 1'b0;
    run_writes(2, 10, cyc);
    chk("stall_post_cycles", 32'(cyc), 32'd2);
    req_valid = 4'h0;

    // Early release: requester 3 drops valid after 2 words, then 0 is granted
    for (int i = 0; i < 4; i++) src_cnt[i] = 8'd0;
    req_valid = 4'b1001;
    push_burst(3, 0, 2, 1'b0);
    run_writes(2, 10, cyc);
    chk("early_pre_cycles", 32'(cyc), 32'd3);
    req_valid = 4'b0001;
    wait_neg();
    chk("early_burst_done", 32'(burst_done), 32'h1);
    chk("early_w_inc", 32'(w_inc), 32'h0);
    chk("early_gnt_id", 32'(gnt_id), 32'h3);
    wait_pos();
    push_burst(0, 0, 4, 1'b1);
    run_writes(4, 10, cyc);
    chk("early_next_cycles", 32'(cyc), 32'd5);
    req_valid = 4'h0;

    // Mid-burst reset after 1 word of requester 2; 0 and 2 both valid
    for (int i = 0; i < 4; i++) src_cnt[i] = 8'd0;
    req_valid = 4'b0101;
    push_burst(2, 0, 1, 1'b0);
    run_writes(1, 10, cyc);
    chk("midrst_pre_cycles", 32'(cyc), 32'd2);
    wrst_n = 1'b0;
    wait_neg();
    chk("midrst_w_inc", 32'(w_inc), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    chk("midrst_burst_done", 32'(burst_done), 32'h0);
    wait_pos();
    wrst_n = 1'b1;
    wait_neg();
    chk("midrst_idle_gnt_valid", 32'(gnt_valid), 32'h0);
    wait_pos();
    push_burst(0, 0, 4, 1'b1);
    run_writes(4, 10, cyc);
    chk("midrst_next_cycles", 32'(cyc), 32'd4);
    req_valid = 4'h0;

    // Quiet tail: nothing further may be written
    for (int k = 0; k < 4; k++) begin
      wait_neg();
      wait_pos();
    end
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
